// File: rtl/utils_pkg.sv
// Shared types for the Ethernet/UDP transmit path: OutFIFO status/command structs,
// UDP length and pointer types, and the transmit-scheduler FSM encoding.
package utils_pkg;

  localparam int unsigned OUTFIFO_KB_SIZE = 2;
  localparam int unsigned OUTFIFO_BYTES   = OUTFIFO_KB_SIZE * 1024;
  // One extra bit so a completely full OutFIFO is distinguishable from empty.
  localparam int unsigned PTR_W           = $clog2(OUTFIFO_BYTES) + 1;

  typedef logic [15:0]      udp_length_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    logic empty;
    logic full;
    logic done;
  } s_fifo_st_t;

  typedef struct packed {
    logic        start;
    udp_length_t length;
    logic        clear;
  } s_fifo_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWaitData,
    StHdr,
    StStream,
    StDone,
    StErr
  } fsm_tx_sched_t;

  // Bytes held in a FIFO; modular subtraction makes pointer wrap transparent.
  function automatic ptr_t fifo_level(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return wr_ptr - rd_ptr;
  endfunction

endpackage

// File: rtl/eth_fifo.sv
// Small synchronous first-word-fall-through FIFO with a synchronous clear.
// A write into a full FIFO is honoured when a read happens in the same cycle.
module eth_fifo #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(SLOTS);

  logic [WIDTH-1:0] mem [SLOTS];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clear_i) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// Transmit sequencer for the OutFIFO: queues send requests, waits for enough data,
// requests a UDP header, then commands the FIFO to stream exactly one packet.
module pkt_tx_sched
  import utils_pkg::*;
#(
  parameter int unsigned REQ_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_LEN     = OUTFIFO_KB_SIZE * 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  udp_length_t req_len_i,
  output logic        req_ready_o,
  input  s_fifo_st_t  fifo_st_i,
  output s_fifo_cmd_t fifo_cmd_o,
  output logic        hdr_valid_o,
  output udp_length_t hdr_len_o,
  input  logic        hdr_ready_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] pkt_cnt_o
);

  // Counter spans 0..TIMEOUT_CYC-1, one value per cycle spent waiting for data.
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  fsm_tx_sched_t state;
  fsm_tx_sched_t state_nxt;

  udp_length_t   len_ff;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]   pkt_cnt;

  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  udp_length_t   q_head;

  ptr_t          level;
  logic          data_ok;
  logic          len_bad;
  logic          tmo_hit;

  s_fifo_cmd_t   cmd_nxt;
  logic          hdr_valid_nxt;
  udp_length_t   hdr_len_nxt;
  logic          done_nxt;
  logic          err_nxt;

  logic          unused_st;

  assign unused_st = fifo_st_i.empty ^ fifo_st_i.full;

  // Request queue; abort flushes it, so a push in the abort cycle is lost.
  assign q_push = req_valid_i && !q_full;
  assign q_pop  = (state == StIdle) && !q_empty && !abort_i;

  eth_fifo #(
    .SLOTS (REQ_DEPTH),
    .WIDTH ($bits(udp_length_t))
  ) u_req_q (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (abort_i),
    .wr_en_i   (q_push),
    .wr_data_i (req_len_i),
    .rd_en_i   (q_pop),
    .rd_data_o (q_head),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  assign req_ready_o = !q_full;
  assign busy_o      = (state != StIdle) || !q_empty;
  assign pkt_cnt_o   = pkt_cnt;

  assign level   = fifo_level(fifo_st_i.wr_ptr, fifo_st_i.rd_ptr);
  assign data_ok = udp_length_t'(level) >= len_ff;
  assign len_bad = (len_ff == '0) || (32'(len_ff) > MAX_LEN);
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      fifo_cmd_o  <= '0;
      hdr_valid_o <= 1'b0;
      hdr_len_o   <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      fifo_cmd_o  <= cmd_nxt;
      hdr_valid_o <= hdr_valid_nxt;
      hdr_len_o   <= hdr_len_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = StIdle;
    end else begin
      unique case (state)
        StIdle:     if (!q_empty) state_nxt = StCheck;
        StCheck:    state_nxt = len_bad ? StErr : StWaitData;
        StWaitData: begin
          if (data_ok)      state_nxt = StHdr;
          else if (tmo_hit) state_nxt = StErr;
        end
        StHdr:      if (hdr_ready_i) state_nxt = StStream;
        StStream:   if (fifo_st_i.done) state_nxt = StDone;
        StDone:     state_nxt = StIdle;
        StErr:      state_nxt = StIdle;
        default:    state_nxt = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    cmd_nxt        = '0;
    cmd_nxt.clear  = abort_i;
    cmd_nxt.start  = (state_nxt == StStream);
    cmd_nxt.length = (state_nxt == StStream) ? len_ff : '0;
    hdr_valid_nxt  = (state_nxt == StHdr);
    hdr_len_nxt    = (state_nxt == StHdr) ? len_ff : '0;
    done_nxt       = (state_nxt == StDone);
    err_nxt        = (state_nxt == StErr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_ff  <= '0;
      tmo_cnt <= '0;
      pkt_cnt <= '0;
    end else begin
      if (q_pop) len_ff <= q_head;
      if (state == StCheck) begin
        tmo_cnt <= '0;
      end else if (state == StWaitData && state_nxt == StWaitData) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (state_nxt == StDone) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Bench for pkt_tx_sched: an OutFIFO/UDP-engine emulation, a transaction-level
// reference model checked every cycle, and directed cases with literal expectations.
module tb_pkt_tx_sched;
  import utils_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam int          MAXL  = OUTFIFO_KB_SIZE * 1024;
  localparam ptr_t        PTR_START = ptr_t'(4000);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  udp_length_t req_len;
  logic        req_ready_o;
  s_fifo_st_t  fifo_st;
  s_fifo_cmd_t fifo_cmd;
  logic        hdr_valid_o;
  udp_length_t hdr_len_o;
  logic        hdr_ready;
  logic        abort;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] pkt_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pkt_tx_sched #(
    .REQ_DEPTH   (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_len_i   (req_len),
    .req_ready_o (req_ready_o),
    .fifo_st_i   (fifo_st),
    .fifo_cmd_o  (fifo_cmd),
    .hdr_valid_o (hdr_valid_o),
    .hdr_len_o   (hdr_len_o),
    .hdr_ready_i (hdr_ready),
    .abort_i     (abort),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  // ---------------- OutFIFO emulation ----------------
  ptr_t wr_p = PTR_START;
  ptr_t rd_p = PTR_START;
  logic st_done;
  logic em_active;
  logic em_sent;
  int   em_dly;
  int   rdy_pct = 100;

  always_comb begin
    fifo_st        = '0;
    fifo_st.rd_ptr = rd_p;
    fifo_st.wr_ptr = wr_p;
    fifo_st.empty  = (wr_p == rd_p);
    fifo_st.full   = ((wr_p - rd_p) == ptr_t'(OUTFIFO_BYTES));
    fifo_st.done   = st_done;
  end

  always @(negedge clk) begin
    if (rst) begin
      rd_p      <= PTR_START;
      st_done   <= 1'b0;
      em_active <= 1'b0;
      em_sent   <= 1'b0;
      em_dly    <= 0;
    end else begin
      st_done <= 1'b0;
      if (fifo_cmd.clear) begin
        rd_p      <= wr_p;
        em_active <= 1'b0;
      end else if (!fifo_cmd.start) begin
        em_active <= 1'b0;
      end else if (!em_active) begin
        em_active <= 1'b1;
        em_sent   <= 1'b0;
        em_dly    <= int'($urandom_range(2, 12));
      end else if (!em_sent) begin
        if (em_dly == 0) begin
          st_done <= 1'b1;
          rd_p    <= rd_p + ptr_t'(fifo_cmd.length);
          em_sent <= 1'b1;
        end else begin
          em_dly <= em_dly - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) hdr_ready <= 1'b0;
    else     hdr_ready <= hdr_valid_o && (int'($urandom_range(0, 99)) < rdy_pct);
  end

  // ---------------- reference model ----------------
  localparam int S_IDLE = 0, S_CHECK = 1, S_WAIT = 2, S_HDR = 3, S_STREAM = 4, S_DONE = 5,
                 S_ERR = 6;

  int          m_q[$];
  int          m_stage = S_IDLE;
  int          m_len = 0;
  int          m_waited = 0;
  logic        m_clear = 1'b0;
  logic [31:0] m_cnt = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_stage = S_IDLE;
        m_len   = 0;
        m_clear = 1'b0;
        m_cnt   = '0;
      end else begin
        int  lvl;
        bit  push;
        push    = req_valid && (m_q.size() < DEPTH);
        m_clear = abort;
        if (abort) begin
          m_q.delete();
          m_stage = S_IDLE;
        end else begin
          case (m_stage)
            S_IDLE: if (m_q.size() > 0) begin
              m_len   = m_q.pop_front();
              m_stage = S_CHECK;
            end
            S_CHECK: begin
              if (m_len == 0 || m_len > MAXL) m_stage = S_ERR;
              else begin
                m_waited = 0;
                m_stage  = S_WAIT;
              end
            end
            S_WAIT: begin
              lvl = (int'(fifo_st.wr_ptr) - int'(fifo_st.rd_ptr) + (1 << PTR_W)) % (1 << PTR_W);
              m_waited++;
              if (lvl >= m_len)        m_stage = S_HDR;
              else if (m_waited >= TMO) m_stage = S_ERR;
            end
            S_HDR:    if (hdr_ready) m_stage = S_STREAM;
            S_STREAM: if (fifo_st.done) begin
              m_stage = S_DONE;
              m_cnt   = m_cnt + 32'd1;
            end
            default:  m_stage = S_IDLE;
          endcase
          if (push) m_q.push_back(int'(req_len));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int   err_seen = 0;
  int   start_rises = 0;
  int   gap = 0;
  logic start_prev = 1'b0;
  bit   pkt_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("req_ready", req_ready_o, m_q.size() < DEPTH);
        chk("busy", busy_o, (m_stage != S_IDLE) || (m_q.size() > 0));
        chk("hdr_valid", hdr_valid_o, m_stage == S_HDR);
        chk("hdr_len", hdr_len_o, (m_stage == S_HDR) ? m_len : 0);
        chk("start", fifo_cmd.start, m_stage == S_STREAM);
        chk("length", fifo_cmd.length, (m_stage == S_STREAM) ? m_len : 0);
        chk("clear", fifo_cmd.clear, m_clear);
        chk("done", done_o, m_stage == S_DONE);
        chk("err", err_o, m_stage == S_ERR);
        chk("pkt_cnt", pkt_cnt_o, m_cnt);
        if (err_o) err_seen++;
        if (fifo_cmd.start && !start_prev) begin
          if (pkt_seen) chk("start_gap_ge2", gap >= 2, 1);
          pkt_seen = 1'b1;
          start_rises++;
        end
        gap        = fifo_cmd.start ? 0 : gap + 1;
        start_prev = fifo_cmd.start;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic evt(input int kind);
    case (kind)
      0:       return hdr_valid_o;
      1:       return done_o;
      2:       return err_o;
      3:       return fifo_cmd.start;
      default: return !busy_o;
    endcase
  endfunction

  task automatic wait_evt(input int kind, input int bound, output int n);
    logic hit;
    n   = 0;
    hit = evt(kind);
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      hit = evt(kind);
    end
    chk($sformatf("wait_evt%0d_reached", kind), hit, 1);
  endtask

  task automatic push(input int len);
    logic acc;
    int   n;
    n         = 0;
    req_valid = 1'b1;
    req_len   = udp_length_t'(len);
    do begin
      acc = req_ready_o;
      @(negedge clk);
      n++;
    end while (!acc && n < 500);
    req_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic add_bytes(input int n);
    wr_p = wr_p + ptr_t'(n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int e0;
    int s0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_len   = '0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_pkt_cnt", pkt_cnt_o, 0);
    chk("rst_start", fifo_cmd.start, 0);
    chk("rst_hdr_valid", hdr_valid_o, 0);
    @(negedge clk);

    // Single packet with data already present.
    add_bytes(64);
    push(64);
    wait_evt(0, 50, n);
    chk("hdr_latency", 1 + n, 4);
    chk("hdr_len_64", hdr_len_o, 64);
    wait_evt(3, 50, n);
    chk("stream_len_64", fifo_cmd.length, 64);
    wait_evt(1, 100, n);
    chk("pkt_cnt_1", pkt_cnt_o, 1);
    repeat (3) @(negedge clk);

    // Starved: data completes while waiting.
    e0 = err_seen;
    add_bytes(40);
    push(100);
    repeat (10) @(negedge clk);
    chk("starved_no_hdr", hdr_valid_o, 0);
    add_bytes(60);
    wait_evt(0, 20, n);
    chk("starved_hdr_len", hdr_len_o, 100);
    wait_evt(1, 100, n);
    chk("starved_no_err", err_seen - e0, 0);
    chk("pkt_cnt_2", pkt_cnt_o, 2);
    repeat (3) @(negedge clk);

    // Bad lengths.
    e0 = err_seen;
    s0 = start_rises;
    push(0);
    push(MAXL + 1);
    repeat (20) @(negedge clk);
    chk("bad_len_errs", err_seen - e0, 2);
    chk("bad_len_no_start", start_rises - s0, 0);
    chk("bad_len_pkt_cnt", pkt_cnt_o, 2);

    // Timeout with an empty OutFIFO.
    push(8);
    wait_evt(2, 60, n);
    chk("timeout_latency", 1 + n, 19);
    @(negedge clk);
    chk("timeout_idle", busy_o, 0);

    // Queue fill while the first request is stalled in the header handshake.
    rdy_pct = 0;
    add_bytes(400);
    push(10);
    push(20);
    push(30);
    push(40);
    push(50);
    chk("queue_full_not_ready", req_ready_o, 0);
    chk("queue_full_busy", busy_o, 1);
    rdy_pct = 100;
    push(60);
    wait_evt(4, 600, n);
    chk("queue_pkt_cnt", pkt_cnt_o, 8);

    // Abort during streaming with requests still queued.
    add_bytes(600);
    push(200);
    push(300);
    push(50);
    wait_evt(3, 60, n);
    e0    = err_seen;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_clear", fifo_cmd.clear, 1);
    chk("abort_start_low", fifo_cmd.start, 0);
    chk("abort_busy_low", busy_o, 0);
    chk("abort_no_done", done_o, 0);
    @(negedge clk);
    chk("abort_clear_once", fifo_cmd.clear, 0);
    chk("abort_pkt_cnt", pkt_cnt_o, 8);
    chk("abort_no_err", err_seen - e0, 0);

    // Randomized traffic.
    rdy_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      int r;
      ptr_t lvl;
      r         = int'($urandom_range(0, 19));
      req_valid = ($urandom_range(0, 3) == 0);
      if (r == 0)      req_len = '0;
      else if (r == 1) req_len = udp_length_t'(MAXL + 1 + int'($urandom_range(0, 1000)));
      else             req_len = udp_length_t'($urandom_range(1, 300));
      abort = ($urandom_range(0, 199) == 0);
      lvl   = wr_p - rd_p;
      if (lvl < ptr_t'(1200) && $urandom_range(0, 2) == 0) add_bytes(int'($urandom_range(1, 64)));
      @(negedge clk);
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    wait_evt(4, 3000, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
